// File: rtl/mem_stage_ext_pkg.sv
// Shared definitions for the MEM stage: access-size codes, FSM states, byte-lane masks.
package mem_stage_ext_pkg;

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzWord = 2'b10;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  localparam logic [3:0] LaneB0  = 4'b0001;
  localparam logic [3:0] LaneLo  = 4'b0011;
  localparam logic [3:0] LaneHi  = 4'b1100;
  localparam logic [3:0] LaneAll = 4'b1111;

  // Size code 2'b11 behaves as a word access.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SzByte:  lane_mask = LaneB0 << a;
      SzHalf:  lane_mask = a[1] ? LaneHi : LaneLo;
      default: lane_mask = LaneAll;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    misaligned = ((size == SzHalf) && a[0]) || (size[1] && (a != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_ext_if.sv
// EX/MEM request and MEM/WB result bundle of the MEM stage.
interface mem_stage_ext_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned WB_W   = 2
);
  logic              valid_i;
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        mem_size;
  logic              mem_unsigned;
  logic [WB_W-1:0]   wbi;
  logic [REG_AW-1:0] regaddr;
  logic [31:0]       data;
  logic [ADDR_W-1:0] dataaddr;

  logic              stall;
  logic [WB_W-1:0]   wbo;
  logic [31:0]       datafrommem;
  logic [31:0]       datafromimm;
  logic [REG_AW-1:0] regaddrout;
  logic              valid_o;
  logic              misalign;

  modport master (
    output valid_i, mem_read, mem_write, mem_size, mem_unsigned, wbi, regaddr, data, dataaddr,
    input  stall, wbo, datafrommem, datafromimm, regaddrout, valid_o, misalign
  );

  modport slave (
    input  valid_i, mem_read, mem_write, mem_size, mem_unsigned, wbi, regaddr, data, dataaddr,
    output stall, wbo, datafrommem, datafromimm, regaddrout, valid_o, misalign
  );
endinterface

// File: rtl/mem_stage_ext_data_ram.sv
// Word-wide data RAM with per-byte write enables and a one-cycle synchronous read.
module mem_stage_ext_data_ram #(
  parameter int unsigned DEPTH_LOG2 = 11
) (
  input  logic                  clk,
  input  logic                  re,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [31:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem_q[addr];
  end
endmodule

// File: rtl/mem_stage_ext.sv
// MIPS MEM stage with byte/half/word loads and stores, load wait states and MEM/WB register.
// Define MEM_MISALIGN_TRAP_EN to flag and suppress misaligned half/word accesses.
module mem_stage_ext
  import mem_stage_ext_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_LOG2  = 11,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned WB_W        = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_stage_ext_if.slave  bus
);
  localparam int unsigned CntW = $clog2(WAIT_CYCLES + 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              stall;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        a;
  logic              mis, is_load, is_store;
  logic [3:0]        we;
  logic [31:0]       wdata, rdata, ext;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;

  logic              valid_q;
  logic [WB_W-1:0]   wbo_q;
  logic [31:0]       dfm_q, imm_q;
  logic [REG_AW-1:0] regaddr_q;
  logic              mis_q;

  assign addr = bus.dataaddr;
  assign a    = addr[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = bus.valid_i && (bus.mem_read || bus.mem_write) && misaligned(bus.mem_size, a);
`else
  assign mis = 1'b0;
`endif

  // A store wins when both request bits are set.
  assign is_store = bus.valid_i && bus.mem_write && !mis;
  assign is_load  = bus.valid_i && bus.mem_read && !bus.mem_write && !mis;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      StIdle: begin
        if (is_load) begin
          stall   = 1'b1;
          state_d = StBusy;
          cnt_d   = CntW'(WAIT_CYCLES - 1);
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          stall = 1'b1;
          cnt_d = cnt_q - CntW'(1);
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!reset) stall = 1'b0;
  end

  assign we = (is_store && reset) ? lane_mask(bus.mem_size, a) : 4'b0000;

  always_comb begin
    case (bus.mem_size)
      SzByte:  wdata = {4{bus.data[7:0]}};
      SzHalf:  wdata = {2{bus.data[15:0]}};
      default: wdata = bus.data;
    endcase
  end

  mem_stage_ext_data_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_data_ram (
    .clk  (clk),
    .re   (is_load),
    .we   (we),
    .addr (addr[DEPTH_LOG2+1:2]),
    .wdata(wdata),
    .rdata(rdata)
  );

  always_comb begin
    case (a)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = a[1] ? rdata[31:16] : rdata[15:0];
    case (bus.mem_size)
      SzByte:  ext = bus.mem_unsigned ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SzHalf:  ext = bus.mem_unsigned ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: ext = rdata;
    endcase
  end

  // While stalled only a bubble enters MEM/WB; the remaining payload holds.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      wbo_q     <= '0;
      dfm_q     <= '0;
      imm_q     <= '0;
      regaddr_q <= '0;
      mis_q     <= 1'b0;
    end else if (!stall) begin
      valid_q   <= bus.valid_i;
      wbo_q     <= (bus.valid_i && !mis) ? bus.wbi : '0;
      dfm_q     <= is_load ? ext : 32'h0;
      imm_q     <= 32'(addr);
      regaddr_q <= bus.regaddr;
      mis_q     <= mis;
    end else begin
      valid_q <= 1'b0;
      wbo_q   <= '0;
    end
  end

  assign bus.stall       = stall;
  assign bus.valid_o     = valid_q;
  assign bus.wbo         = wbo_q;
  assign bus.datafrommem = dfm_q;
  assign bus.datafromimm = imm_q;
  assign bus.regaddrout  = regaddr_q;
  assign bus.misalign    = mis_q;
endmodule

// File: tb/tb_mem_stage_ext.sv
// Scoreboard bench for mem_stage_ext with three load wait states.
module tb_mem_stage_ext;
  import mem_stage_ext_pkg::*;

  localparam int unsigned Wait = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_stage_ext_if #(.ADDR_W(32), .REG_AW(5), .WB_W(2)) bus ();

  mem_stage_ext #(
    .ADDR_W     (32),
    .DEPTH_LOG2 (11),
    .WAIT_CYCLES(Wait),
    .REG_AW     (5),
    .WB_W       (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic        v;
    logic [1:0]  wb;
    logic [4:0]  ra;
    logic        mis;
    logic [31:0] dfm;
    logic [31:0] imm;
  } res_t;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dfm;
    bit          chk;
    bit          mis;
  } op_t;

  typedef struct {
    string name;
    res_t  r;
    bit    chk_dfm;
    int    stalls;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic res_t observed();
    observed = {bus.valid_o, bus.wbo, bus.regaddrout, bus.misalign, bus.datafrommem,
                bus.datafromimm};
  endfunction

  function automatic op_t mk_op(input string name, input logic rd, input logic wr,
                                input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] dfm, input bit chk,
                                input bit mis);
    mk_op = '{name, rd, wr, sz, uns, addr, wdata, dfm, chk, mis};
  endfunction

  task automatic idle_inputs();
    bus.valid_i      = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.mem_size     = 2'b00;
    bus.mem_unsigned = 1'b0;
    bus.wbi          = 2'b00;
    bus.regaddr      = 5'd0;
    bus.data         = 32'h0;
    bus.dataaddr     = 32'h0;
  endtask

  task automatic set_inputs(input op_t op, input logic [4:0] ra, input logic [1:0] wb);
    bus.valid_i      = 1'b1;
    bus.mem_read     = op.rd;
    bus.mem_write    = op.wr;
    bus.mem_size     = op.sz;
    bus.mem_unsigned = op.uns;
    bus.wbi          = wb;
    bus.regaddr      = ra;
    bus.data         = op.wdata;
    bus.dataaddr     = op.addr;
  endtask

  task automatic push_exp(input op_t op, input logic [4:0] ra, input logic [1:0] wb);
    exp_t e;
    e.name    = op.name;
    e.r.v     = 1'b1;
    e.r.wb    = op.mis ? 2'b00 : wb;
    e.r.ra    = ra;
    e.r.mis   = op.mis;
    e.r.dfm   = op.mis ? 32'h0 : op.dfm;
    e.r.imm   = op.addr;
    e.chk_dfm = op.chk || op.mis;
    e.stalls  = (op.rd && !op.wr && !op.mis) ? int'(Wait) : 0;
    sbq.push_back(e);
  endtask

  // Presents one op after a posedge, holds it through any stall, releases it after acceptance.
  task automatic issue(input op_t op, input logic [4:0] ra, input logic [1:0] wb,
                       output int stalls);
    bit done = 1'b0;
    @(posedge clk);
    #1;
    set_inputs(op, ra, wb);
    push_exp(op, ra, wb);
    stalls = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.stall !== 1'b1) done = 1'b1;
      else begin
        stalls++;
        @(posedge clk);
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: stall still high after %0d cycles, want low", op.name, stalls);
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    op_t op;
    int  quiet;
    reset = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (observed() !== '0 || bus.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init: got %h stall %b, want 0 stall 0", observed(), bus.stall);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    op = mk_op("nop", 1'b0, 1'b0, SzWord, 1'b0, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 1'b0);
    set_inputs(op, 5'd7, 2'd3);
    @(posedge clk);
    #1;
    op = mk_op("lw0", 1'b1, 1'b0, SzWord, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_inputs(op, 5'd4, 2'd1);
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.stall !== 1'b1 || bus.datafromimm !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL reset_busy: got stall %b imm %h, want 1 00001234", bus.stall,
               bus.datafromimm);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.stall !== 1'b0 || observed() !== '0 || dut.state_q !== StIdle) begin
      n_fail++;
      $display("FAIL reset_midload: got stall %b out %h state %0d, want 0 0 idle", bus.stall,
               observed(), dut.state_q);
    end
    idle_inputs();
    @(posedge clk);
    #1;
    reset = 1'b1;
    quiet = 0;
    repeat (Wait + 3) begin
      @(negedge clk);
      if (bus.valid_o !== 1'b0) quiet++;
    end
    n_checks++;
    if (quiet != 0) begin
      n_fail++;
      $display("FAIL reset_abandon: got %0d valid_o cycles, want 0", quiet);
    end
  endtask

  task automatic test_sizes();
    op_t  ops[$];
    exp_t e;
    res_t got;
    int   st;
    ops.push_back(mk_op("sw10", 0, 1, SzWord, 0, 32'h10, 32'h8081_82F3, 0, 0, 0));
    ops.push_back(mk_op("lb10", 1, 0, SzByte, 0, 32'h10, 0, 32'hFFFF_FFF3, 1, 0));
    ops.push_back(mk_op("lbu10", 1, 0, SzByte, 1, 32'h10, 0, 32'h0000_00F3, 1, 0));
    ops.push_back(mk_op("lh12", 1, 0, SzHalf, 0, 32'h12, 0, 32'hFFFF_8081, 1, 0));
    ops.push_back(mk_op("lhu10", 1, 0, SzHalf, 1, 32'h10, 0, 32'h0000_82F3, 1, 0));
    ops.push_back(mk_op("lb13", 1, 0, SzByte, 0, 32'h13, 0, 32'hFFFF_FF80, 1, 0));
    ops.push_back(mk_op("lbu11", 1, 0, SzByte, 1, 32'h11, 0, 32'h0000_0082, 1, 0));
    ops.push_back(mk_op("lw10", 1, 0, 2'b11, 0, 32'h10, 0, 32'h8081_82F3, 1, 0));
    foreach (ops[i]) begin
      issue(ops[i], 5'(i + 3), 2'(i), st);
      @(negedge clk);
      e   = sbq.pop_front();
      got = observed();
      if (!e.chk_dfm) got.dfm = e.r.dfm;
      n_checks++;
      if (got !== e.r || st != e.stalls) begin
        n_fail++;
        $display("FAIL %s: got %h stalls %0d, want %h stalls %0d", e.name, got, st, e.r,
                 e.stalls);
      end
    end
  endtask

  task automatic test_store_lanes();
    op_t  ops[$];
    exp_t e;
    res_t got;
    int   st;
    ops.push_back(mk_op("sw20", 0, 1, SzWord, 0, 32'h20, 32'h0, 0, 0, 0));
    ops.push_back(mk_op("sb21", 0, 1, SzByte, 0, 32'h21, 32'h1234_56AA, 0, 0, 0));
    ops.push_back(mk_op("sh22", 0, 1, SzHalf, 0, 32'h22, 32'hDEAD_BEEF, 0, 0, 0));
    ops.push_back(mk_op("lw20", 1, 0, SzWord, 0, 32'h20, 0, 32'hBEEF_AA00, 1, 0));
    foreach (ops[i]) begin
      issue(ops[i], 5'(31 - i), 2'(i + 1), st);
      @(negedge clk);
      e   = sbq.pop_front();
      got = observed();
      if (!e.chk_dfm) got.dfm = e.r.dfm;
      n_checks++;
      if (got !== e.r || st != e.stalls) begin
        n_fail++;
        $display("FAIL %s: got %h stalls %0d, want %h stalls %0d", e.name, got, st, e.r,
                 e.stalls);
      end
    end
  endtask

  task automatic test_wait_states();
    op_t        op;
    exp_t       e;
    logic [7:0] sv, vv, sv_exp;
    sv = '0;
    vv = '0;
    op = mk_op("lw20_wait", 1, 0, SzWord, 0, 32'h20, 0, 32'hBEEF_AA00, 1, 0);
    @(posedge clk);
    #1;
    set_inputs(op, 5'd9, 2'd2);
    push_exp(op, 5'd9, 2'd2);
    for (int k = 0; k <= int'(Wait); k++) begin
      @(negedge clk);
      sv[k] = bus.stall;
      vv[k] = bus.valid_o;
      @(posedge clk);
    end
    #1;
    idle_inputs();
    sv_exp = '0;
    for (int k = 0; k < int'(Wait); k++) sv_exp[k] = 1'b1;
    n_checks++;
    if (sv !== sv_exp) begin
      n_fail++;
      $display("FAIL wait_stall: got pattern %b, want %b", sv, sv_exp);
    end
    n_checks++;
    if (vv[Wait:1] !== '0) begin
      n_fail++;
      $display("FAIL wait_bubble: got valid_o pattern %b, want 0 in cycles 1..%0d", vv, Wait);
    end
    @(negedge clk);
    e = sbq.pop_front();
    n_checks++;
    if (observed() !== e.r) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", e.name, observed(), e.r);
    end
  endtask

  task automatic test_misalign();
    op_t  ops[$];
    exp_t e;
    res_t got;
    int   st;
    ops.push_back(mk_op("sw30", 0, 1, SzWord, 0, 32'h30, 32'h1122_3344, 0, 0, 0));
`ifdef MEM_MISALIGN_TRAP_EN
    ops.push_back(mk_op("sh33", 0, 1, SzHalf, 0, 32'h33, 32'h0000_5566, 0, 1, 1));
    ops.push_back(mk_op("lh31", 1, 0, SzHalf, 0, 32'h31, 0, 32'h0, 1, 1));
    ops.push_back(mk_op("lw30", 1, 0, SzWord, 0, 32'h30, 0, 32'h1122_3344, 1, 0));
`else
    ops.push_back(mk_op("sh33", 0, 1, SzHalf, 0, 32'h33, 32'h0000_5566, 0, 0, 0));
    ops.push_back(mk_op("lh31", 1, 0, SzHalf, 0, 32'h31, 0, 32'h0000_3344, 1, 0));
    ops.push_back(mk_op("lw30", 1, 0, SzWord, 0, 32'h30, 0, 32'h5566_3344, 1, 0));
`endif
    foreach (ops[i]) begin
      issue(ops[i], 5'(i + 12), 2'(3 - i), st);
      @(negedge clk);
      e   = sbq.pop_front();
      got = observed();
      if (!e.chk_dfm) got.dfm = e.r.dfm;
      n_checks++;
      if (got !== e.r || st != e.stalls) begin
        n_fail++;
        $display("FAIL %s: got %h stalls %0d, want %h stalls %0d", e.name, got, st, e.r,
                 e.stalls);
      end
    end
  endtask

  task automatic test_invalid();
    op_t  op;
    exp_t e;
    int   st;
    @(posedge clk);
    #1;
    op = mk_op("inv_sw", 1, 1, SzWord, 0, 32'h30, 32'hFFFF_FFFF, 0, 0, 0);
    set_inputs(op, 5'd5, 2'd3);
    bus.valid_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL inv_stall: got %b, want 0", bus.stall);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (bus.valid_o !== 1'b0 || bus.wbo !== 2'b00) begin
      n_fail++;
      $display("FAIL inv_out: got valid_o %b wbo %b, want 0 00", bus.valid_o, bus.wbo);
    end
`ifdef MEM_MISALIGN_TRAP_EN
    op = mk_op("inv_lw30", 1, 0, SzWord, 0, 32'h30, 0, 32'h1122_3344, 1, 0);
`else
    op = mk_op("inv_lw30", 1, 0, SzWord, 0, 32'h30, 0, 32'h5566_3344, 1, 0);
`endif
    issue(op, 5'd6, 2'd1, st);
    @(negedge clk);
    e = sbq.pop_front();
    n_checks++;
    if (observed() !== e.r || st != e.stalls) begin
      n_fail++;
      $display("FAIL %s: got %h stalls %0d, want %h stalls %0d", e.name, observed(), st, e.r,
               e.stalls);
    end
  endtask

  task automatic test_back_to_back();
    op_t  ld, sw, ld2;
    exp_t e;
    res_t got;
    int   st;
    ld  = mk_op("b2b_lw10", 1, 0, SzWord, 0, 32'h10, 0, 32'h8081_82F3, 1, 0);
    sw  = mk_op("b2b_sw40", 0, 1, SzWord, 0, 32'h40, 32'hCAFE_F00D, 0, 0, 0);
    ld2 = mk_op("b2b_lw40", 1, 0, SzWord, 0, 32'h40, 0, 32'hCAFE_F00D, 1, 0);
    issue(ld, 5'd20, 2'd1, st);
    set_inputs(sw, 5'd21, 2'd2);
    push_exp(sw, 5'd21, 2'd2);
    @(negedge clk);
    e = sbq.pop_front();
    n_checks++;
    if (observed() !== e.r || st != e.stalls || bus.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got %h stalls %0d next-stall %b, want %h stalls %0d next-stall 0",
               e.name, observed(), st, bus.stall, e.r, e.stalls);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    e   = sbq.pop_front();
    got = observed();
    got.dfm = e.r.dfm;
    n_checks++;
    if (got !== e.r) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", e.name, got, e.r);
    end
    issue(ld2, 5'd22, 2'd3, st);
    @(negedge clk);
    e = sbq.pop_front();
    n_checks++;
    if (observed() !== e.r || st != e.stalls) begin
      n_fail++;
      $display("FAIL %s: got %h stalls %0d, want %h stalls %0d", e.name, observed(), st, e.r,
               e.stalls);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sizes();
    test_store_lanes();
    test_wait_states();
    test_misalign();
    test_invalid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
